// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and the fetch state type
package cpu_pkg;

    localparam logic [3:0]  OPC_HLT  = 4'hF;
    localparam logic [15:0] PC_RESET = 16'h0000;
    localparam logic [15:0] PC_STEP  = 16'd2;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DISCARD = 2'd1,
        HALT    = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry skid buffer holding a fetched {pc, instr} pair
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic        consume,
    input  logic [31:0] load_data,
    output logic        valid,
    output logic [31:0] data
);

    // Clear (flush) beats load; load and consume never coincide because a
    // load only happens while the buffer is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= 32'h0000_0000;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with skid buffer and redirect handling (optional FETCH_PERF_EN wait counter)
module fetch_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic        valid_out,
    output logic [15:0] pc_out,
    output logic [15:0] instr_out,
    output logic        hlt_out
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_wait_cnt
`endif
);

    fetch_state_t state_q;
    logic [15:0]  pc_q;
    logic [15:0]  target_q;

    logic         buf_valid;
    logic [31:0]  buf_data;
    logic [15:0]  buf_pc;
    logic [15:0]  buf_instr;

    logic         fetch_req;
    logic         direct;
    logic         pres_valid;
    logic [15:0]  pres_pc;
    logic [15:0]  pres_instr;
    logic         consume;
    logic [15:0]  target_pc;

    assign buf_pc    = buf_data[31:16];
    assign buf_instr = buf_data[15:0];
    assign target_pc = redirect_pc & 16'hFFFE;

    // Request and presentation are combinational so zero-wait memory streams
    // one word per cycle; reset gates them off immediately.
    always_comb begin
        fetch_req  = rst && (((state_q == RUN) && !buf_valid) || (state_q == DISCARD));
        direct     = fetch_req && (state_q == RUN) && imem_ready;
        pres_pc    = buf_valid ? buf_pc : pc_q;
        pres_instr = buf_valid ? buf_instr : imem_data;
        pres_valid = rst && !redirect && (buf_valid || direct);
        consume    = pres_valid && !stall;
    end

    assign imem_req  = fetch_req;
    assign imem_addr = pc_q;
    assign valid_out = pres_valid;
    assign pc_out    = pres_valid ? pres_pc : 16'h0000;
    assign instr_out = pres_valid ? pres_instr : 16'h0000;
    assign hlt_out   = pres_valid && (pres_instr[15:12] == OPC_HLT);

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (direct && stall && !redirect),
        .clear     (redirect),
        .consume   (buf_valid && consume),
        .load_data ({pc_q, imem_data}),
        .valid     (buf_valid),
        .data      (buf_data)
    );

    // Fetch FSM: redirect first, then advance on accepted words, drain DISCARD, park in HALT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            pc_q     <= PC_RESET;
            target_q <= PC_RESET;
        end else if (redirect) begin
            if (fetch_req && !imem_ready) begin
                target_q <= target_pc;
                state_q  <= DISCARD;
            end else begin
                pc_q    <= target_pc;
                state_q <= RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (direct) begin
                        pc_q <= pc_q + PC_STEP;
                        if (imem_data[15:12] == OPC_HLT) begin
                            state_q <= HALT;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_ready) begin
                        pc_q    <= target_q;
                        state_q <= RUN;
                    end
                end
                HALT: begin
                end
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating count of cycles spent waiting on instruction memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_wait_cnt <= 16'h0000;
        end else if (fetch_req && !imem_ready && (perf_wait_cnt != 16'hFFFF)) begin
            perf_wait_cnt <= perf_wait_cnt + 16'd1;
        end
    end
`endif

endmodule
